// File: rtl/pce_bk_pkg.sv
// pce_bk_pkg: shared types and constants for the PC Engine backup RAM save controller
package pce_bk_pkg;
  typedef enum logic [1:0] {IDLE, REQ, ACK, FMT} bk_state_t;
  localparam int BK_SECTORS = 16;
  localparam int BK_FMT_WORDS = 4;
  localparam logic [15:0] BK_FMT_HDR [BK_FMT_WORDS] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
  function automatic logic [15:0] bk_fmt_word(input logic [1:0] idx);
    return BK_FMT_HDR[idx];
  endfunction
endpackage

// File: rtl/bk_edge.sv
// bk_edge: one-flop rising/falling edge detector for a vector of level inputs
// Ports: clk_i/rst_ni clock and async active-low reset, d_i levels,
//        rise_o/fall_o combinational edge strobes (valid in the cycle the level changes).
module bk_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] d_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) d_q <= '0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/bram_save_ctrl.sv
// bram_save_ctrl: sequences the backup RAM image between port B of the dpram and the HPS sector interface
// Inputs : clk_sys, reset_n, download/img_* mount status, load/save/format_req OSD levels,
//          autosave_en, osd_open, bram_wr CPU write strobe, sd_ack host acknowledge.
// Outputs: sd_lba/sd_rd/sd_wr sector requests, fmt_active/fmt_addr/fmt_we format writer,
//          ena, busy, loading, pending, timeout_err status (all registered).
module bram_save_ctrl
  import pce_bk_pkg::*;
#(
  parameter int          SECTORS   = BK_SECTORS,
  parameter int          FMT_WORDS = BK_FMT_WORDS,
  parameter logic [23:0] TIMEOUT   = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        download,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        img_size_nz,
  input  logic        load_req,
  input  logic        save_req,
  input  logic        format_req,
  input  logic        autosave_en,
  input  logic        osd_open,
  input  logic        bram_wr,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        fmt_active,
  output logic [1:0]  fmt_addr,
  output logic        fmt_we,
  output logic        ena,
  output logic        busy,
  output logic        loading,
  output logic        pending,
  output logic        timeout_err
);
  localparam int SW = $clog2(SECTORS);
  localparam logic [1:0] FLAST = 2'(FMT_WORDS - 1);

  bk_state_t   state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  faddr_q, faddr_d;
  logic rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, loading_q, loading_d, terr_q, terr_d;
  logic fa_q, fa_d, fwe_q, fwe_d, ena_q, ena_d, pend_q, pend_d;
  logic [4:0] rise, fall;
  logic [2:0] unused_fall;
  logic save_src, load_t, save_t, start;

  // Autosave fires on the edge of the combined condition, so holding the OSD open saves once.
  assign save_src = save_req | (pend_q & osd_open & autosave_en);

  bk_edge #(.W(5)) u_edge (
    .clk_i (clk_sys),
    .rst_ni(reset_n),
    .d_i   ({sd_ack, download, format_req, save_src, load_req}),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign unused_fall = fall[2:0];

  assign load_t = rise[0] | (fall[3] & img_size_nz);
  assign save_t = rise[1];
  assign start  = ena_q & (load_t | save_t);
  assign ena_d  = (download & img_mounted & ~img_readonly) ? 1'b1 : rise[3] ? 1'b0 : ena_q;
  assign pend_d = (ena_q & ~osd_open & bram_wr) ? 1'b1 : busy_q ? 1'b0 : pend_q;

  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    loading_d = loading_q;
    terr_d    = terr_q;
    fa_d      = 1'b0;
    fwe_d     = 1'b0;
    faddr_d   = 2'd0;
    unique case (state_q)
      IDLE:
        if (start) begin
          state_d   = REQ;
          lba_d     = 32'd0;
          cnt_d     = 24'd0;
          rd_d      = load_t;
          wr_d      = ~load_t;
          busy_d    = 1'b1;
          loading_d = load_t;
          terr_d    = 1'b0;
        end else if (rise[2]) begin
          state_d = FMT;
          fa_d    = 1'b1;
          fwe_d   = 1'b1;
        end
      REQ:
        if (rise[4]) begin
          state_d = ACK;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (cnt_q == TIMEOUT - 24'd1) begin
          state_d   = IDLE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          busy_d    = 1'b0;
          loading_d = 1'b0;
          terr_d    = 1'b1;
        end else cnt_d = cnt_q + 24'd1;
      ACK:
        if (fall[4]) begin
          if (&lba_q[SW-1:0]) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            loading_d = 1'b0;
          end else begin
            state_d = REQ;
            lba_d   = lba_q + 32'd1;
            cnt_d   = 24'd0;
            rd_d    = loading_q;
            wr_d    = ~loading_q;
          end
        end
      FMT:
        if (faddr_q != FLAST) begin
          fa_d    = 1'b1;
          fwe_d   = 1'b1;
          faddr_d = faddr_q + 2'd1;
        end else state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      lba_q     <= '0;
      cnt_q     <= '0;
      faddr_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      loading_q <= 1'b0;
      terr_q    <= 1'b0;
      fa_q      <= 1'b0;
      fwe_q     <= 1'b0;
      ena_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      cnt_q     <= cnt_d;
      faddr_q   <= faddr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
      loading_q <= loading_d;
      terr_q    <= terr_d;
      fa_q      <= fa_d;
      fwe_q     <= fwe_d;
      ena_q     <= ena_d;
      pend_q    <= pend_d;
    end

  assign sd_lba      = lba_q;
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign fmt_active  = fa_q;
  assign fmt_addr    = faddr_q;
  assign fmt_we      = fwe_q;
  assign ena         = ena_q;
  assign busy        = busy_q;
  assign loading     = loading_q;
  assign pending     = pend_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_bram_save_ctrl.sv
// tb_bram_save_ctrl: scoreboard bench for bram_save_ctrl with a randomized host and operation mix
module tb_bram_save_ctrl;
  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] v;
  } ev_t;

  logic clk_sys = 1'b0, reset_n = 1'b0;
  logic download = 0, img_mounted = 0, img_readonly = 0, img_size_nz = 0;
  logic load_req = 0, save_req = 0, format_req = 0, autosave_en = 0, osd_open = 0, bram_wr = 0, sd_ack = 0;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, fmt_active, fmt_we, ena, busy, loading, pending, timeout_err;
  logic [1:0] fmt_addr;

  int n_cmp = 0, n_err = 0;
  ev_t exp_q[$];
  logic host_en = 1, h_fixed = 0;
  logic m_pending = 0;

  always #5 clk_sys = ~clk_sys;

  bram_save_ctrl #(.TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .download(download), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size_nz(img_size_nz), .load_req(load_req), .save_req(save_req),
    .format_req(format_req), .autosave_en(autosave_en), .osd_open(osd_open), .bram_wr(bram_wr),
    .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .fmt_active(fmt_active),
    .fmt_addr(fmt_addr), .fmt_we(fmt_we), .ena(ena), .busy(busy), .loading(loading),
    .pending(pending), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic push_xfer(input logic [1:0] k);
    ev_t e;
    for (int s = 0; s < 16; s++) begin
      e.k = k;
      e.v = 32'(s);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_fmt();
    ev_t e;
    for (int a = 0; a < 4; a++) begin
      e.k = 2'd3;
      e.v = 32'(a);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    tick(2);
    while ((busy || fmt_active) && n < 5000) begin
      n++;
      tick(1);
    end
    chk("idle_reached", {62'd0, busy, fmt_active}, 64'd0);
  endtask

  // Host: acknowledges each sector request after a delay, holds ack, then releases it.
  initial forever begin
    @(negedge clk_sys);
    if (host_en && reset_n && (sd_rd || sd_wr) && !sd_ack) begin
      repeat (h_fixed ? 3 : $urandom_range(0, 3)) @(negedge clk_sys);
      sd_ack = 1'b1;
      repeat (h_fixed ? 5 : $urandom_range(1, 4)) @(negedge clk_sys);
      sd_ack = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every new request or format write and checks ack protocol.
  initial begin
    logic rd_p, wr_p, ack_p;
    logic [31:0] lba_p;
    ev_t e;
    rd_p = 0; wr_p = 0; ack_p = 0; lba_p = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset_n) begin
        if ((sd_rd && !rd_p) || (sd_wr && !wr_p)) begin
          chk("rd_wr_exclusive", {63'd0, sd_rd & sd_wr}, 64'd0);
          if (exp_q.size() == 0) chk("unexpected_req", {30'd0, sd_rd ? 2'd1 : 2'd2, sd_lba}, 64'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("xfer_req", {30'd0, sd_rd ? 2'd1 : 2'd2, sd_lba}, {30'd0, e});
          end
        end
        if (fmt_we) begin
          if (exp_q.size() == 0) chk("unexpected_fmt", {62'd0, fmt_addr}, 64'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("fmt_write", {30'd0, 2'd3, 30'd0, fmt_addr}, {30'd0, e});
          end
        end
        if (fmt_active || fmt_we) chk("fmt_frame", {62'd0, fmt_active, sd_rd | sd_wr}, {62'd0, fmt_we, 1'b0});
        if (sd_ack && !ack_p && (rd_p || wr_p)) chk("req_drop_after_ack", {62'd0, sd_rd, sd_wr}, 64'd0);
        if (sd_lba != lba_p) chk("lba_step_ack_low", {63'd0, sd_ack}, 64'd0);
      end
      rd_p = sd_rd; wr_p = sd_wr; ack_p = sd_ack; lba_p = sd_lba;
    end
  end

  initial begin
    #600000;
    n_err++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    int cnt, op;
    tick(3);
    chk("rst_outputs", {sd_lba, 23'd0, sd_rd, sd_wr, fmt_active, fmt_addr, fmt_we, ena, busy, loading, pending, timeout_err}, 64'd0);
    reset_n = 1'b1;
    tick(2);
    chk("post_rst_ena", {63'd0, ena}, 64'd0);

    // Mount with auto-load: ena set wins over the download-edge clear.
    download = 1; img_mounted = 1; img_size_nz = 1;
    tick(1);
    img_mounted = 0;
    tick(1);
    chk("mount_ena", {63'd0, ena}, 64'd1);
    push_xfer(2'd1);
    download = 0;
    tick(1);
    chk("autoload_start", {62'd0, loading, busy}, 64'd3);
    wait_idle();
    chk("autoload_end", {30'd0, loading, busy, sd_lba}, 64'd15);

    // Manual save with a scripted 3/5 host.
    h_fixed = 1;
    push_xfer(2'd2);
    save_req = 1;
    tick(1);
    save_req = 0;
    chk("save_busy", {62'd0, busy, loading}, 64'd2);
    wait_idle();
    chk("save_end_lba", {32'd0, sd_lba}, 64'd15);
    h_fixed = 0;

    // Autosave on OSD open.
    autosave_en = 1;
    bram_wr = 1;
    tick(1);
    bram_wr = 0;
    tick(1);
    chk("pending_set", {63'd0, pending}, 64'd1);
    push_xfer(2'd2);
    osd_open = 1;
    tick(2);
    chk("autosave_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    chk("autosave_pending_clr", {63'd0, pending}, 64'd0);
    bram_wr = 1;
    tick(1);
    bram_wr = 0;
    tick(2);
    chk("osd_wr_no_pending", {62'd0, pending, busy}, 64'd0);
    osd_open = 0;
    autosave_en = 0;
    tick(2);

    // Format.
    push_fmt();
    format_req = 1;
    tick(1);
    format_req = 0;
    wait_idle();
    chk("fmt_done", {62'd0, busy, fmt_active}, 64'd0);

    // Conflicts: load+save -> read only; save and format during load dropped; format+load -> load.
    push_xfer(2'd1);
    load_req = 1; save_req = 1;
    tick(1);
    load_req = 0; save_req = 0;
    wait_idle();
    push_xfer(2'd1);
    load_req = 1;
    tick(1);
    load_req = 0;
    tick(3);
    save_req = 1; format_req = 1;
    tick(1);
    save_req = 0; format_req = 0;
    wait_idle();
    push_xfer(2'd1);
    load_req = 1; format_req = 1;
    tick(1);
    load_req = 0; format_req = 0;
    wait_idle();

    // Read-only image: ena cleared and load/save triggers ignored; format still accepted.
    download = 1; img_mounted = 1; img_readonly = 1;
    tick(1);
    img_mounted = 0;
    tick(1);
    download = 0;
    tick(2);
    load_req = 1;
    tick(1);
    load_req = 0;
    tick(1);
    save_req = 1;
    tick(1);
    save_req = 0;
    tick(3);
    chk("ro_ignored", {62'd0, ena, busy}, 64'd0);
    push_fmt();
    format_req = 1;
    tick(1);
    format_req = 0;
    wait_idle();

    // Writable remount with an empty image: ena but no auto-load.
    download = 1; img_mounted = 1; img_readonly = 0; img_size_nz = 0;
    tick(1);
    img_mounted = 0;
    tick(1);
    download = 0;
    tick(3);
    chk("remount_no_load", {62'd0, ena, busy}, 64'd2);

    // Timeout with a silent host.
    host_en = 0;
    begin
      ev_t e;
      e.k = 2'd2;
      e.v = 32'd0;
      exp_q.push_back(e);
    end
    save_req = 1;
    tick(1);
    save_req = 0;
    cnt = 0;
    while (sd_wr && cnt < 1000) begin
      cnt++;
      tick(1);
    end
    chk("timeout_cycles", 64'(cnt), 64'd100);
    chk("timeout_flags", {61'd0, timeout_err, busy, sd_wr}, 64'd4);
    host_en = 1;
    push_xfer(2'd2);
    save_req = 1;
    tick(1);
    save_req = 0;
    chk("timeout_err_clr", {62'd0, timeout_err, busy}, 64'd1);
    wait_idle();

    // Randomized operation mix against the pending/scoreboard model.
    m_pending = 0;
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        push_xfer(2'd1);
        format_req = 1'($urandom_range(0, 1));
        load_req = 1;
        tick(1);
        load_req = 0; format_req = 0;
        wait_idle();
        m_pending = 0;
      end else if (op == 1) begin
        push_xfer(2'd2);
        save_req = 1;
        tick(1);
        save_req = 0;
        wait_idle();
        m_pending = 0;
      end else if (op == 2) begin
        push_fmt();
        format_req = 1;
        tick(1);
        format_req = 0;
        wait_idle();
      end else begin
        bram_wr = 1;
        tick(1);
        bram_wr = 0;
        tick(1);
        m_pending = 1;
      end
      chk("rand_pending", {63'd0, pending}, {63'd0, m_pending});
    end

    tick(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
